// File: rtl/aes_uart_pkg.sv
// Shared types and constants for the AES-UART transmit path.
package aes_uart_pkg;

  localparam int unsigned AES_BLOCK_BYTES = 16;
  localparam int unsigned AES_BLOCK_BITS  = AES_BLOCK_BYTES * 8;
  localparam int unsigned AES_CNT_W       = $clog2(AES_BLOCK_BYTES + 1);
  localparam int unsigned AES_IDX_W       = $clog2(AES_BLOCK_BYTES);

  typedef enum logic [2:0] {
    IDLE,
    PASS,
    COLLECT,
    AES_REQ,
    AES_WAIT,
    SEND
  } tx_sched_state_e;

endpackage

// File: rtl/aes_uart_blk_serdes.sv
// 16-byte block register: packs plaintext bytes MSB-first and unpacks ciphertext bytes.
module aes_uart_blk_serdes
  import aes_uart_pkg::*;
#(
  parameter int unsigned BLOCK_BYTES = AES_BLOCK_BYTES
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_push,
  input  logic [7:0]               i_byte,
  input  logic                     i_clr_cnt,
  input  logic                     i_load,
  input  logic [BLOCK_BYTES*8-1:0] i_ct,
  input  logic                     i_adv,
  output logic [BLOCK_BYTES*8-1:0] o_block,
  output logic [AES_CNT_W-1:0]     o_cnt,
  output logic [7:0]               o_byte,
  output logic                     o_last
);

  logic [BLOCK_BYTES*8-1:0] r_buf;
  logic [AES_CNT_W-1:0]     r_cnt;
  logic [AES_IDX_W-1:0]     r_idx;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_buf <= '0;
      r_cnt <= '0;
      r_idx <= '0;
    end else begin
      if (i_load) begin
        r_buf <= i_ct;
        r_idx <= '0;
      end else if (i_push) begin
        // Constant-index byte lanes keep the write decode free of variable part-selects.
        for (int unsigned i = 0; i < BLOCK_BYTES; i++) begin
          if (r_cnt == AES_CNT_W'(i))
            r_buf[(BLOCK_BYTES-1-i)*8 +: 8] <= i_byte;
        end
      end
      if (i_clr_cnt)
        r_cnt <= '0;
      else if (i_push)
        r_cnt <= r_cnt + AES_CNT_W'(1);
      if (i_adv && !i_load)
        r_idx <= r_idx + AES_IDX_W'(1);
    end
  end

  always_comb begin
    o_byte = '0;
    for (int unsigned i = 0; i < BLOCK_BYTES; i++) begin
      if (r_idx == AES_IDX_W'(i))
        o_byte = r_buf[(BLOCK_BYTES-1-i)*8 +: 8];
    end
  end

  assign o_block = r_buf;
  assign o_cnt   = r_cnt;
  assign o_last  = (r_idx == AES_IDX_W'(BLOCK_BYTES - 1));

endmodule

// File: rtl/aes_uart_tx_sched.sv
// Transmit sequencer: TXFIFO -> (optional AES block encryption) -> UART, plus busy/ere/tc status.
module aes_uart_tx_sched
  import aes_uart_pkg::*;
#(
  parameter int unsigned BLOCK_BYTES = 16,
  parameter int unsigned INFLT_W     = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cfg_aue,
  input  logic         cfg_te,
  input  logic         cfg_ee,
  input  logic [7:0]   fifo_tdata,
  input  logic         fifo_tvalid,
  output logic         fifo_tready,
  output logic [127:0] aes_in_tdata,
  output logic         aes_in_tvalid,
  input  logic         aes_in_tready,
  input  logic [127:0] aes_out_tdata,
  input  logic         aes_out_tvalid,
  output logic         aes_out_tready,
  output logic [7:0]   tx_tdata,
  output logic         tx_tvalid,
  input  logic         tx_tready,
  input  logic         tx_done,
  output logic         busy,
  output logic         ere,
  output logic         tc_set
);

  if (BLOCK_BYTES != AES_BLOCK_BYTES) begin : g_bad_block_bytes
    $error("aes_uart_tx_sched: BLOCK_BYTES must be 16");
  end

  tx_sched_state_e      r_state, w_state_nxt;
  logic                 r_pass_valid;
  logic [7:0]           r_pass_data;
  logic [INFLT_W-1:0]   r_inflt, w_inflt_nxt;
  logic                 r_busy, r_tc;
  logic                 w_rst, w_pop, w_tx_acc, w_aes_in_acc, w_aes_out_acc;
  logic                 w_inc, w_dec, w_tc_nxt;
  logic [AES_CNT_W-1:0] w_cnt;
  logic [7:0]           w_ser_byte;
  logic                 w_ser_last;
  logic [127:0]         w_block;

  // cfg_aue=0 acts exactly like the external reset.
  assign w_rst         = rst | ~cfg_aue;
  assign w_pop         = fifo_tvalid & fifo_tready;
  assign w_tx_acc      = tx_tvalid & tx_tready;
  assign w_aes_in_acc  = aes_in_tvalid & aes_in_tready;
  assign w_aes_out_acc = aes_out_tvalid & aes_out_tready;

  aes_uart_blk_serdes #(
    .BLOCK_BYTES(AES_BLOCK_BYTES)
  ) u_serdes (
    .i_clk    (clk),
    .i_rst    (w_rst),
    .i_push   ((r_state == COLLECT) & w_pop),
    .i_byte   (fifo_tdata),
    .i_clr_cnt(w_aes_in_acc),
    .i_load   (w_aes_out_acc),
    .i_ct     (aes_out_tdata),
    .i_adv    ((r_state == SEND) & w_tx_acc),
    .o_block  (w_block),
    .o_cnt    (w_cnt),
    .o_byte   (w_ser_byte),
    .o_last   (w_ser_last)
  );

  always_ff @(posedge clk) begin
    if (w_rst) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:     if (cfg_te && fifo_tvalid) w_state_nxt = cfg_ee ? COLLECT : PASS;
      PASS:     if (!r_pass_valid && !w_pop) w_state_nxt = IDLE;
      COLLECT:  if (w_pop && w_cnt == AES_CNT_W'(AES_BLOCK_BYTES - 1)) w_state_nxt = AES_REQ;
      AES_REQ:  if (aes_in_tready) w_state_nxt = AES_WAIT;
      AES_WAIT: if (aes_out_tvalid) w_state_nxt = SEND;
      SEND:     if (tx_tready && w_ser_last) w_state_nxt = IDLE;
      default:  w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    fifo_tready    = 1'b0;
    aes_in_tvalid  = 1'b0;
    aes_out_tready = 1'b0;
    tx_tvalid      = r_pass_valid;
    tx_tdata       = r_pass_data;
    case (r_state)
      PASS:     fifo_tready    = cfg_te & ~r_pass_valid;
      COLLECT:  fifo_tready    = cfg_te;
      AES_REQ:  aes_in_tvalid  = 1'b1;
      AES_WAIT: aes_out_tready = 1'b1;
      SEND: begin
        tx_tvalid = 1'b1;
        tx_tdata  = w_ser_byte;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_rst) begin
      r_pass_valid <= 1'b0;
      r_pass_data  <= '0;
    end else if (r_state == PASS && w_pop) begin
      r_pass_valid <= 1'b1;
      r_pass_data  <= fifo_tdata;
    end else if (w_tx_acc) begin
      r_pass_valid <= 1'b0;
    end
  end

  // A done with nothing outstanding is stray and must not underflow.
  assign w_inc = w_tx_acc;
  assign w_dec = tx_done & (r_inflt != '0);

  always_comb begin
    w_inflt_nxt = r_inflt;
    if (w_inc && !w_dec && r_inflt != '1) w_inflt_nxt = r_inflt + INFLT_W'(1);
    else if (w_dec && !w_inc)             w_inflt_nxt = r_inflt - INFLT_W'(1);
  end

  assign w_tc_nxt = w_dec && (w_inflt_nxt == '0) && !tx_tvalid && !fifo_tvalid &&
                    (r_state == IDLE || r_state == COLLECT);

  always_ff @(posedge clk) begin
    if (w_rst) begin
      r_inflt <= '0;
      r_busy  <= 1'b0;
      r_tc    <= 1'b0;
    end else begin
      r_inflt <= w_inflt_nxt;
      r_busy  <= (r_state != IDLE) | (w_cnt != '0) | (r_inflt != '0);
      r_tc    <= w_tc_nxt;
    end
  end

  assign aes_in_tdata = w_block;
  assign busy         = r_busy;
  assign ere          = (w_cnt == '0);
  assign tc_set       = r_tc;

endmodule

// File: tb/tb_aes_uart_tx_sched.sv
// Directed + randomized bench for aes_uart_tx_sched with queue-based reference model.
module tb_aes_uart_tx_sched;

  logic         clk = 1'b0;
  logic         rst, cfg_aue, cfg_te, cfg_ee;
  logic [7:0]   fifo_tdata;
  logic         fifo_tvalid, fifo_tready;
  logic [127:0] aes_in_tdata;
  logic         aes_in_tvalid, aes_in_tready;
  logic [127:0] aes_out_tdata;
  logic         aes_out_tvalid, aes_out_tready;
  logic [7:0]   tx_tdata;
  logic         tx_tvalid, tx_tready, tx_done;
  logic         busy, ere, tc_set;

  aes_uart_tx_sched #(.BLOCK_BYTES(16), .INFLT_W(2)) dut (
    .clk(clk), .rst(rst), .cfg_aue(cfg_aue), .cfg_te(cfg_te), .cfg_ee(cfg_ee),
    .fifo_tdata(fifo_tdata), .fifo_tvalid(fifo_tvalid), .fifo_tready(fifo_tready),
    .aes_in_tdata(aes_in_tdata), .aes_in_tvalid(aes_in_tvalid), .aes_in_tready(aes_in_tready),
    .aes_out_tdata(aes_out_tdata), .aes_out_tvalid(aes_out_tvalid), .aes_out_tready(aes_out_tready),
    .tx_tdata(tx_tdata), .tx_tvalid(tx_tvalid), .tx_tready(tx_tready), .tx_done(tx_done),
    .busy(busy), .ere(ere), .tc_set(tc_set)
  );

  always #5 clk = ~clk;

  localparam logic [127:0] CT_FIXED = 128'h69C4E0D86A7B0430D8CDB78070B4C55A;
  localparam logic [127:0] PT_SEQ   = 128'h000102030405060708090A0B0C0D0E0F;

  int n_chk = 0, n_err = 0, cyc = 0;
  int n_tc = 0, n_aes_in = 0, n_aes_out = 0;
  int last_done = 0, aes_cd = 0;
  logic [7:0] q_fifo[$], q_exp[$], q_plain[$];
  int q_done[$];
  bit model_ee = 0, tx_stall = 0, aes_hold = 0, aes_freeze = 0, aes_fixed = 0, aes_pend = 0;
  logic [127:0] aes_ct = '0, last_aes_in = '0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] pack16();
    logic [127:0] b = 'x;
    for (int i = 0; i < 16; i++)
      if (q_plain.size() != 0) b[127-8*i -: 8] = q_plain.pop_front();
    return b;
  endfunction

  task automatic push(input logic [7:0] b);
    q_fifo.push_back(b);
    fifo_tvalid = 1'b1;
    fifo_tdata  = q_fifo[0];
  endtask

  // One clock: observe handshakes just before the edge, then drive the next inputs.
  task automatic step();
    logic [7:0] b, exp8;
    int nd;
    #3;
    if (fifo_tvalid && fifo_tready && q_fifo.size() != 0) begin
      b = q_fifo.pop_front();
      if (model_ee) q_plain.push_back(b); else q_exp.push_back(b);
    end
    if (tx_tvalid && tx_tready) begin
      if (q_exp.size() != 0) exp8 = q_exp.pop_front(); else exp8 = 'x;
      chk("tx_byte", {120'd0, tx_tdata}, {120'd0, exp8});
      nd = cyc + 8 + int'($urandom_range(0, 4));
      if (nd <= last_done) nd = last_done + 1;
      last_done = nd;
      q_done.push_back(nd);
    end
    if (aes_in_tvalid && aes_in_tready) begin
      n_aes_in++;
      last_aes_in = aes_in_tdata;
      chk("aes_in_block", aes_in_tdata, pack16());
      aes_ct   = aes_fixed ? CT_FIXED : {$urandom(), $urandom(), $urandom(), $urandom()};
      aes_pend = 1;
      aes_cd   = int'($urandom_range(0, 3));
    end
    if (aes_out_tvalid && aes_out_tready) begin
      n_aes_out++;
      for (int i = 0; i < 16; i++) q_exp.push_back(aes_ct[127-8*i -: 8]);
      aes_pend = 0;
    end
    if (tc_set) n_tc++;
    @(posedge clk); #1;
    cyc++;
    fifo_tvalid = (q_fifo.size() != 0);
    fifo_tdata  = fifo_tvalid ? q_fifo[0] : 8'h00;
    tx_done = 1'b0;
    if (q_done.size() != 0 && q_done[0] <= cyc) begin
      void'(q_done.pop_front());
      tx_done = 1'b1;
    end
    tx_tready     = !tx_stall && q_done.size() < 2 && $urandom_range(0, 3) != 0;
    aes_in_tready = ($urandom_range(0, 2) == 0);
    if (aes_pend && !aes_out_tvalid) begin
      if (aes_cd == 0 && !aes_freeze) begin
        aes_out_tvalid = 1'b1;
        aes_out_tdata  = aes_ct;
      end else if (aes_cd > 0) aes_cd--;
    end else if (!aes_pend && !aes_hold) aes_out_tvalid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int k = 0;
    while ((q_fifo.size() + q_exp.size() + q_done.size() + q_plain.size() + int'(aes_pend)) != 0
           && k < 3000) begin
      step();
      k++;
    end
    repeat (4) step();
    chk(tag, q_fifo.size() + q_exp.size() + q_done.size() + q_plain.size() + int'(aes_pend), 0);
  endtask

  task automatic chk_reset(input string p);
    chk({p, "_fifo_tready"}, fifo_tready, 0);
    chk({p, "_aes_in_tvalid"}, aes_in_tvalid, 0);
    chk({p, "_aes_in_tdata"}, aes_in_tdata, 0);
    chk({p, "_aes_out_tready"}, aes_out_tready, 0);
    chk({p, "_tx_tvalid"}, tx_tvalid, 0);
    chk({p, "_tx_tdata"}, tx_tdata, 0);
    chk({p, "_busy"}, busy, 0);
    chk({p, "_ere"}, ere, 1);
    chk({p, "_tc_set"}, tc_set, 0);
  endtask

  initial begin
    int tc0, ain0, out0, k, n;
    bit e;
    rst = 1; cfg_aue = 1; cfg_te = 1; cfg_ee = 0;
    fifo_tdata = '0; fifo_tvalid = 0; aes_in_tready = 0;
    aes_out_tdata = '0; aes_out_tvalid = 0; tx_tready = 0; tx_done = 0;
    @(posedge clk); #1;
    step(); step();
    chk_reset("rst");
    rst = 0;

    // 1: plain pass-through
    model_ee = 0; cfg_ee = 0; tc0 = n_tc;
    push(8'h55); push(8'hA3);
    drain("t1_drain");
    chk("t1_tc_count", n_tc - tc0, 1);
    chk("t1_busy", busy, 0);

    // 2: one encrypted block with known vectors
    cfg_ee = 1; model_ee = 1; aes_fixed = 1; tc0 = n_tc;
    for (int i = 0; i < 16; i++) push(8'(i));
    drain("t2_drain");
    chk("t2_aes_in", last_aes_in, PT_SEQ);
    chk("t2_tc_count", n_tc - tc0, 1);
    aes_fixed = 0;

    // 3: partial block waits, soft reset discards it
    tc0 = n_tc; ain0 = n_aes_in;
    for (int i = 0; i < 5; i++) push(8'($urandom()));
    repeat (30) step();
    chk("t3_no_aes_req", n_aes_in - ain0, 0);
    chk("t3_aes_in_tvalid", aes_in_tvalid, 0);
    chk("t3_ere", ere, 0);
    chk("t3_busy", busy, 1);
    chk("t3_tc_count", n_tc - tc0, 0);
    cfg_aue = 0; step(); cfg_aue = 1;
    q_plain.delete();
    chk("t3_ere_after", ere, 1);
    chk("t3_busy_after", busy, 0);

    // 4: transmitter stall during SEND, AES output held valid
    aes_hold = 1; out0 = n_aes_out;
    for (int i = 0; i < 16; i++) push(8'($urandom()));
    k = 0;
    while (n_aes_out == out0 && k < 500) begin step(); k++; end
    chk("t4_aes_out_acc", n_aes_out - out0, 1);
    tx_stall = 1; tx_tready = 0;
    step();
    for (int i = 0; i < 20; i++) begin
      step();
      chk("t4_hold_valid", tx_tvalid, 1);
      chk("t4_hold_data", tx_tdata, q_exp[0]);
      chk("t4_aes_out_tready", aes_out_tready, 0);
    end
    tx_stall = 0;
    drain("t4_drain");
    aes_hold = 0; step();
    chk("t4_single_accept", n_aes_out - out0, 1);

    // 5: ee flip while in PASS
    cfg_ee = 0; model_ee = 0; tc0 = n_tc;
    for (int i = 0; i < 3; i++) push(8'($urandom()));
    k = 0;
    while (q_fifo.size() == 3 && k < 100) begin step(); k++; end
    cfg_ee = 1;
    drain("t5_plain_drain");
    chk("t5_tc_plain", n_tc - tc0, 1);
    ain0 = n_aes_in; model_ee = 1;
    for (int i = 0; i < 16; i++) push(8'($urandom()));
    drain("t5_enc_drain");
    chk("t5_aes_blocks", n_aes_in - ain0, 1);
    chk("t5_tc_total", n_tc - tc0, 2);

    // 6: reset while waiting for AES, then a stray tx_done
    aes_freeze = 1; ain0 = n_aes_in;
    for (int i = 0; i < 16; i++) push(8'($urandom()));
    k = 0;
    while (n_aes_in == ain0 && k < 500) begin step(); k++; end
    repeat (3) step();
    chk("t6_in_wait", aes_out_tready, 1);
    rst = 1; step(); rst = 0;
    q_plain.delete(); q_exp.delete(); aes_pend = 0; aes_freeze = 0; aes_out_tvalid = 0;
    chk_reset("t6");
    tc0 = n_tc;
    tx_done = 1; step(); step(); step();
    chk("t6_stray_tc", n_tc - tc0, 0);
    chk("t6_busy", busy, 0);

    // randomized mixed traffic
    for (int r = 0; r < 4; r++) begin
      e = 1'($urandom_range(0, 1));
      cfg_ee = e; model_ee = e; tc0 = n_tc;
      n = e ? 16 * int'($urandom_range(1, 2)) : int'($urandom_range(1, 6));
      for (int i = 0; i < n; i++) push(8'($urandom()));
      drain("rnd_drain");
      chk("rnd_tc_count", n_tc - tc0, 1);
      chk("rnd_ere", ere, 1);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
